// File: rtl/demux_3bit_1to4.sv
// demux_3bit_1to4: routes one input word to one of four single-entry output
// buffers, chosen by a 2-bit selector, using valid/ready handshakes on both
// sides. A buffer that drains and receives a word in the same cycle passes
// data through without a bubble. accept_count counts accepted words and
// wraps on overflow.
module demux_3bit_1to4 #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       selector,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [CNT_W-1:0] accept_count
);

    // Turn a channel index into a one-hot mask. Every selector value maps
    // to exactly one channel; the default arm keeps the decode total.
    function automatic logic [3:0] chan_onehot(input logic [1:0] idx);
        logic [3:0] mask;
        case (idx)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0010;
            2'd2:    mask = 4'b0100;
            2'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Buffer state: one data word and one FULL flag for each channel
    logic [WIDTH-1:0] data_r [4];
    logic [3:0]       valid_r;
    logic [CNT_W-1:0] count_r;

    // Handshake decode
    logic [3:0] sel_onehot_s;
    logic       sel_full_s;
    logic       sel_taking_s;
    logic       in_ready_s;
    logic       accept_s;
    logic [3:0] load_s;
    logic [3:0] drain_s;
    logic [3:0] valid_nxt_s;

    // Locate the destination channel and read its FULL flag and consumer ready
    always_comb begin
        sel_onehot_s = chan_onehot(selector);
        sel_full_s   = |(valid_r & sel_onehot_s);
        sel_taking_s = |(out_ready & sel_onehot_s);
    end

    // Input readiness: the destination is free, or its consumer takes the
    // old word this cycle. in_valid is deliberately not an input here, and
    // nothing is ready while reset is held.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst_n && enable) begin
            in_ready_s = (~sel_full_s) | sel_taking_s;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Accept and load decode: only the selected channel receives the word
    always_comb begin
        accept_s = in_valid & in_ready_s;
        load_s   = 4'b0000;
        if (accept_s) begin
            load_s = sel_onehot_s;
        end else begin
            load_s = 4'b0000;
        end
    end

    // Drain decode: a ready consumer on an empty channel does nothing. A
    // load wins over a drain on the same channel, so the flag stays set.
    always_comb begin
        drain_s     = valid_r & out_ready;
        valid_nxt_s = load_s | (valid_r & ~drain_s);
    end

    // FULL flags for all four channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 4'b0000;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Channel data registers. A register loads only when its own channel
    // accepts a word, and otherwise holds its value, including while EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= in_data;
                end
            end
        end
    end

    // Accepted-word counter, wrapping modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = valid_r;
    assign out0         = data_r[0];
    assign out1         = data_r[1];
    assign out2         = data_r[2];
    assign out3         = data_r[3];
    assign accept_count = count_r;

endmodule

// File: tb/tb_demux_3bit_1to4.sv
// Self-checking bench for demux_3bit_1to4. A behavioural model tracks what
// each channel holds. A compare process checks every output on each falling
// clock edge. Directed scenarios also pin the model to hand-computed values.
module tb_demux_3bit_1to4;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       selector = 2'd0;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = 4'b0000;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic [CNT_W-1:0] accept_count;

    int checks = 0;
    int errors = 0;

    // Model state: what each channel holds, and the number of words taken
    int m_data [4] = '{0, 0, 0, 0};
    bit m_full [4] = '{0, 0, 0, 0};
    int m_count = 0;

    demux_3bit_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .selector(selector),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .accept_count(accept_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The block can take a word when not in reset, routing is enabled, and
    // the destination is either empty or being emptied this cycle
    function automatic bit model_ready();
        return (rst_n === 1'b1) && (enable === 1'b1) &&
               (!m_full[selector] || out_ready[selector]);
    endfunction

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_data[i] = 0;
            m_full[i] = 0;
        end
        m_count = 0;
    endtask

    // Model: asynchronous reset empties everything at once
    always @(negedge rst_n) model_clear();

    // Model: apply the drains, then the accept, at each rising edge
    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            model_clear();
        end else begin
            bit acc;
            acc = in_valid && model_ready();
            for (int i = 0; i < 4; i++) begin
                if (m_full[i] && out_ready[i]) m_full[i] = 0;
            end
            if (acc) begin
                m_data[selector] = int'(in_data);
                m_full[selector] = 1;
                m_count = (m_count + 1) % (1 << CNT_W);
            end
        end
    end

    // Compare process: check every output against the model mid-cycle
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(model_valid_vec()));
        check("out0", 32'(out0), m_data[0]);
        check("out1", 32'(out1), m_data[1]);
        check("out2", 32'(out2), m_data[2]);
        check("out3", 32'(out3), m_data[3]);
        check("accept_count", 32'(accept_count), m_count);
        check("in_ready", 32'(in_ready), 32'(model_ready()));
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        enable = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(accept_count), 32'h0);
        #1 check("rst_in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;

        // Four words, one to each channel, with no consumer ready
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            selector = 2'(k);
            in_data  = 3'(k + 4);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", 32'(out_valid), 32'hF);
        check("fill_out0", 32'(out0), 32'd4);
        check("fill_out1", 32'(out1), 32'd5);
        check("fill_out2", 32'(out2), 32'd6);
        check("fill_out3", 32'(out3), 32'd7);
        check("fill_count", 32'(accept_count), 32'd4);

        // A full channel blocks the input until its consumer becomes ready
        in_valid = 1'b1;
        selector = 2'd2;
        in_data  = 3'd1;
        #1 check("full_block", 32'(in_ready), 32'h0);
        tick();
        check("full_hold", 32'(out2), 32'd6);
        out_ready = 4'b0100;
        #1 check("pass_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("pass_out2", 32'(out2), 32'd1);
        check("pass_valid", 32'(out_valid), 32'hF);
        check("pass_count", 32'(accept_count), 32'd5);

        // Drains continue while enable is low
        enable    = 1'b0;
        out_ready = 4'b1111;
        tick();
        check("dis_valid", 32'(out_valid), 32'h0);
        check("dis_count", 32'(accept_count), 32'd5);
        #1 check("dis_ready", 32'(in_ready), 32'h0);
        out_ready = 4'b0000;
        enable    = 1'b1;

        // Back-to-back streaming on channel 3 wraps the counter to 0
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        in_valid  = 1'b1;
        selector  = 2'd3;
        out_ready = 4'b1000;
        for (int k = 0; k < 256; k++) begin
            in_data = 3'($urandom_range(0, 7));
            tick();
        end
        in_valid = 1'b0;
        check("wrap_count", 32'(accept_count), 32'd0);
        check("wrap_valid3", 32'(out_valid[3]), 32'h1);
        tick();
        out_ready = 4'b0000;

        // An asynchronous reset between edges clears buffered words at once
        in_valid = 1'b1;
        selector = 2'd0;
        in_data  = 3'd3;
        tick();
        selector = 2'd2;
        in_data  = 3'd5;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h5);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_out0", 32'(out0), 32'h0);
        check("async_out2", 32'(out2), 32'h0);
        check("async_count", 32'(accept_count), 32'h0);
        rst_n = 1'b1;

        // Changing the selector from a full channel to an empty one
        in_valid = 1'b1;
        selector = 2'd1;
        in_data  = 3'd2;
        tick();
        in_data = 3'd6;
        #1 check("sw_blocked", 32'(in_ready), 32'h0);
        selector = 2'd0;
        #1 check("sw_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("sw_out0", 32'(out0), 32'd6);
        check("sw_out1", 32'(out1), 32'd2);
        check("sw_valid", 32'(out_valid), 32'h3);

        // Random traffic, with occasional mid-cycle reset pulses
        for (int k = 0; k < 3000; k++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            selector  = 2'($urandom_range(0, 3));
            in_data   = 3'($urandom_range(0, 7));
            out_ready = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
